psad_min_select: RTL and testbench
==================================

# psad_min_select

Consumer at the output end of the absolute-difference systolic array. Accepts packed per-lane partial-SAD vectors leaving the last AD stage, one vector per search row. Across a complete search window it finds the minimum SAD and its (row, lane) candidate position, then presents the winner through a valid/ready handshake to the motion-vector stage.

## Interface
- `PIXELS_IN_BATCH`, 16, lanes per input vector (candidates per search row)
- `INPUT_PSAD_BITS_PER_PIXEL`, 11, width of each lane's SAD value
- `SEARCH_ROWS`, 16, vectors per search window; must be ≥ 2
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `psad_in` input `INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH`: lane i occupies bits `[(i+1)*W-1 : i*W]`
- `in_valid` input 1: `psad_in` holds a valid row vector
- `in_ready` output 1: block accepts a vector this cycle
- `best_sad` output `INPUT_PSAD_BITS_PER_PIXEL`: minimum SAD of the window
- `best_row` output `$clog2(SEARCH_ROWS)`: beat index of the winner
- `best_lane` output `$clog2(PIXELS_IN_BATCH)`: lane index of the winner
- `out_valid` output 1: result valid
- `out_ready` input 1: downstream takes the result

## Operation
- A beat is accepted when `in_valid && in_ready`. The row counter increments on each accepted beat and is 0 for the first beat of a window.
- Stage 1 (registered) reduces the accepted vector to its minimum lane value and that lane's index. On ties the lower lane index wins.
- Stage 2 (registered) compares the stage-1 result against the running minimum:
  - Row 0 loads unconditionally.
  - Later rows replace the running minimum only if strictly smaller, so ties keep the earlier row.
- All comparisons are unsigned at full lane width. No widening and no wrap are possible.
- State machine:
  - IDLE: `in_ready`=1. First accepted beat → ACCUM.
  - ACCUM: `in_ready`=1. Beat with row = `SEARCH_ROWS-1` → DRAIN.
  - DRAIN: `in_ready`=0. Stays 2 cycles while the pipeline empties → DONE.
  - DONE: `out_valid`=1 and outputs stable. `out_ready` → IDLE, and the row counter clears.
- Gaps in `in_valid` during ACCUM are allowed. The pipeline advances only on accepted beats plus the drain.
- `rst` in any state forces IDLE, clears the counter, and discards partial results. The next window starts from row 0.
- Reset values: `in_ready`=0 during reset and 1 the cycle after; `out_valid`=0; `best_sad`, `best_row`, `best_lane`=0.

## Timing
- Latency: `out_valid` rises 3 cycles after the clock edge that accepts the last beat.
- Back-to-back windows:
  - DONE with `out_ready`=1 returns to IDLE the next cycle.
  - `in_ready` is low for the whole of DRAIN and DONE.
  - Minimum window period is `SEARCH_ROWS`+3 cycles with `out_ready` tied high.
- `out_valid` stays high and outputs stay unchanged until `out_ready` is sampled high.

## Configuration
- `PSAD_MIN_SAT_FLAG_EN` defined:
  - Adds output `sat_seen` (1 bit), reset 0.
  - `sat_seen` is set if any accepted lane in the window equals all-ones (`2^W-1`, possible overflow).
  - It is valid with `out_valid` and clears on the IDLE transition.
- Not defined: the port is absent and no saturation logic is built.

## Structure
- Shared package `psad_min_pkg` holds:
  - State enum (IDLE, ACCUM, DRAIN, DONE).
  - Localparam functions for row and lane index widths.
- Sub-module `psad_lane_min_tree`: combinational binary min-tree over `PIXELS_IN_BATCH` lanes returning value and index, with lower-index-wins tie rule. Stage 1 registers its output.

## Test plan
- Ramp row, 16 rows:
  - Stimulus: row r has lane i = 100+r+i, except row 5 lane 9 = 3.
  - Required: `best_sad`=3, `best_row`=5, `best_lane`=9, `out_valid` 3 cycles after the 16th beat.
- Ties:
  - Stimulus: all lanes = 50, every row.
  - Required: `best_sad`=50, `best_row`=0, `best_lane`=0.
- Bubbles and backpressure:
  - Stimulus: `in_valid` toggles 1-0 through the window; `out_ready` held low 10 cycles.
  - Required: result identical to the gap-free run; `out_valid` and outputs stable until `out_ready`; `in_ready`=0 throughout.
- Reset mid-window:
  - Stimulus: `rst` after 7 beats of window A, then a full window B whose minimum is 20 at row 15 lane 0. Window A's first 7 beats include a value of 1.
  - Required: result `best_sad`=20, `best_row`=15, `best_lane`=0.
- Extremes:
  - Stimulus: one lane = 0, all other lanes = 2047.
  - Required: `best_sad`=0.
  - With `PSAD_MIN_SAT_FLAG_EN`: `sat_seen`=1; a window with max 2046 gives `sat_seen`=0.
- Back-to-back windows:
  - Stimulus: two windows with `out_ready` tied high.
  - Required: second result correct, first beat of the second window accepted exactly one cycle after the first result handshake.

Source files
------------

// File: rtl/psad_min_pkg.sv
// Shared types and width helpers for the PSAD minimum selector.
// Optional saturation flag: PSAD_MIN_SAT_FLAG_EN.
package psad_min_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/psad_lane_min_tree.sv
// Combinational binary min-tree over one row vector.
// Left child wins ties, so the lowest lane index is reported.
module psad_lane_min_tree
  import psad_min_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 11
) (
  input  logic [N*W-1:0]         vec_i,
  output logic [W-1:0]           min_o,
  output logic [lane_w(N)-1:0]   idx_o
);

  localparam int LW = lane_w(N);
  localparam int NP = 1 << LW;

  logic [W-1:0]  v [2*NP-1];
  logic [LW-1:0] x [2*NP-1];

  always_comb begin
    for (int i = 0; i < 2*NP-1; i++) begin
      v[i] = '1;
      x[i] = '0;
    end
    // pad leaves carry max value and high index, so real lanes win
    for (int i = 0; i < NP; i++) begin
      if (i < N) v[NP-1+i] = vec_i[i*W +: W];
      else       v[NP-1+i] = '1;
      x[NP-1+i] = LW'(i);
    end
    for (int k = NP-2; k >= 0; k--) begin
      if (v[2*k+1] <= v[2*k+2]) begin
        v[k] = v[2*k+1];
        x[k] = x[2*k+1];
      end else begin
        v[k] = v[2*k+2];
        x[k] = x[2*k+2];
      end
    end
    min_o = v[0];
    idx_o = x[0];
  end

endmodule

// File: rtl/psad_min_select.sv
// Window-wide SAD minimum search with valid/ready result handoff.
// PSAD_MIN_SAT_FLAG_EN adds the sat_seen all-ones lane flag.
module psad_min_select
  import psad_min_pkg::*;
#(
  parameter int PIXELS_IN_BATCH           = 16,
  parameter int INPUT_PSAD_BITS_PER_PIXEL = 11,
  parameter int SEARCH_ROWS               = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] psad_in,
  input  logic in_valid,
  output logic in_ready,
  output logic [INPUT_PSAD_BITS_PER_PIXEL-1:0] best_sad,
  output logic [row_w(SEARCH_ROWS)-1:0] best_row,
  output logic [lane_w(PIXELS_IN_BATCH)-1:0] best_lane,
  output logic out_valid,
  input  logic out_ready
`ifdef PSAD_MIN_SAT_FLAG_EN
  ,
  output logic sat_seen
`endif
);

  localparam int N  = PIXELS_IN_BATCH;
  localparam int W  = INPUT_PSAD_BITS_PER_PIXEL;
  localparam int RW = row_w(SEARCH_ROWS);
  localparam int LW = lane_w(PIXELS_IN_BATCH);

  state_e        state_q;
  logic [RW-1:0] row_q;
  logic          drn_q;
  logic          rdy_q;
  logic          ov_q;

  logic          s1_vld_q;
  logic          s1_first_q;
  logic [W-1:0]  s1_val_q;
  logic [LW-1:0] s1_idx_q;
  logic [RW-1:0] s1_row_q;

  logic [W-1:0]  min_q,  min_d;
  logic [RW-1:0] mrow_q, mrow_d;
  logic [LW-1:0] mlane_q, mlane_d;

  logic [W-1:0]  tree_val;
  logic [LW-1:0] tree_idx;
  logic          accept;
  logic          last_row;
  logic          upd;

  assign in_ready = rdy_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign last_row = row_q == RW'(SEARCH_ROWS-1);

  psad_lane_min_tree #(
    .N (N),
    .W (W)
  ) u_tree (
    .vec_i (psad_in),
    .min_o (tree_val),
    .idx_o (tree_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      drn_q   <= 1'b0;
      rdy_q   <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            row_q   <= row_q + RW'(1);
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_row) begin
              row_q   <= '0;
              drn_q   <= 1'b0;
              rdy_q   <= 1'b0;
              state_q <= DRAIN;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        DRAIN: begin
          if (drn_q) begin
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            drn_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            rdy_q   <= 1'b1;
            row_q   <= '0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // row 0 seeds the running minimum; later rows need a strict win
  always_comb begin
    upd     = s1_vld_q && (s1_first_q || (s1_val_q < min_q));
    min_d   = upd ? s1_val_q : min_q;
    mrow_d  = upd ? s1_row_q : mrow_q;
    mlane_d = upd ? s1_idx_q : mlane_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_val_q   <= '0;
      s1_idx_q   <= '0;
      s1_row_q   <= '0;
      min_q      <= '0;
      mrow_q     <= '0;
      mlane_q    <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_first_q <= row_q == '0;
        s1_val_q   <= tree_val;
        s1_idx_q   <= tree_idx;
        s1_row_q   <= row_q;
      end
      min_q   <= min_d;
      mrow_q  <= mrow_d;
      mlane_q <= mlane_d;
    end
  end

  assign best_sad  = min_q;
  assign best_row  = mrow_q;
  assign best_lane = mlane_q;
  assign out_valid = ov_q;

`ifdef PSAD_MIN_SAT_FLAG_EN
  logic sat_q;
  logic lane_sat;

  always_comb begin
    lane_sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (psad_in[i*W +: W] == '1) lane_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state_q == DONE && out_ready) begin
      sat_q <= 1'b0;
    end else if (accept && lane_sat) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_seen = sat_q;
`endif

endmodule

// File: tb/tb_psad_min_select.sv
// Directed bench for psad_min_select.
// Covers PSAD_MIN_SAT_FLAG_EN builds when the macro is defined.
module tb_psad_min_select;

  localparam int N = 16;
  localparam int W = 11;
  localparam int R = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] psad_in;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   best_sad;
  logic [3:0]     best_row;
  logic [3:0]     best_lane;
  logic           out_valid;
  logic           out_ready;
`ifdef PSAD_MIN_SAT_FLAG_EN
  logic           sat_seen;
`endif

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  psad_min_select #(
    .PIXELS_IN_BATCH           (N),
    .INPUT_PSAD_BITS_PER_PIXEL (W),
    .SEARCH_ROWS               (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psad_in   (psad_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .best_sad  (best_sad),
    .best_row  (best_row),
    .best_lane (best_lane),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PSAD_MIN_SAT_FLAG_EN
    ,
    .sat_seen  (sat_seen)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  function automatic logic [W-1:0] lane_val(input int s, input int r, input int i);
    case (s)
      0:       return (r == 5 && i == 9) ? 11'd3 : W'(100 + r + i);
      1:       return 11'd50;
      2:       return (r == 3 && i == 4) ? 11'd1 : 11'd200;
      3:       return (r == 15 && i == 0) ? 11'd20 : 11'd300;
      4:       return (r == 7 && i == 12) ? 11'd0 : 11'd2047;
      5:       return (r == 0 && i == 3) ? 11'd1000 : 11'd2046;
      6:       return (r == 10 && i == 2) ? 11'd7 : 11'd400;
      default: return ((r == 0 || r == 14) && i == 15) ? 11'd9 : 11'd600;
    endcase
  endfunction

  task automatic drive_row(input int s, input int r);
    for (int i = 0; i < N; i++) psad_in[i*W +: W] = lane_val(s, r, i);
  endtask

  task automatic send_beat(input int s, input int r);
    int n;
    @(negedge clk);
    drive_row(s, r);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout row %0d: in_ready 0, required 1", r);
    end
    @(posedge clk);
  endtask

  task automatic send_window(input int s, input int first, input int last, input bit gap);
    for (int r = first; r <= last; r++) begin
      send_beat(s, r);
      if (gap && r < last) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  // n = negedges after the last accepting edge until out_valid
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 30);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    psad_in = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL rst_in_ready: got %b, required 0", in_ready);
    end
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rst_out_valid: got %b, required 0", out_valid);
    end
    nvec++;
    if ({best_sad, best_row, best_lane} !== 19'd0) begin
      nfail++;
      $display("FAIL rst_best: got %0d/%0d/%0d, required 0/0/0",
               best_sad, best_row, best_lane);
    end
`ifdef PSAD_MIN_SAT_FLAG_EN
    nvec++;
    if (sat_seen !== 1'b0) begin
      nfail++;
      $display("FAIL rst_sat: got %b, required 0", sat_seen);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL post_rst_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_ramp();
    int n;
    send_window(0, 0, R-1, 1'b0);
    wait_out(n);
    nvec++;
    if (n !== 3) begin
      nfail++;
      $display("FAIL ramp_latency: got %0d cycles, required 3", n);
    end
    nvec++;
    if (best_sad !== 11'd3 || best_row !== 4'd5 || best_lane !== 4'd9) begin
      nfail++;
      $display("FAIL ramp_result: got %0d/%0d/%0d, required 3/5/9",
               best_sad, best_row, best_lane);
    end
    nvec++;
    if (in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL ramp_done_ready: got %b, required 0", in_ready);
    end
    handshake();
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL ramp_release: got ov=%b rdy=%b, required ov=0 rdy=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_ties();
    int n;
    send_window(1, 0, R-1, 1'b0);
    wait_out(n);
    nvec++;
    if (n !== 3 || best_sad !== 11'd50 || best_row !== 4'd0 || best_lane !== 4'd0) begin
      nfail++;
      $display("FAIL ties_result: got lat=%0d %0d/%0d/%0d, required lat=3 50/0/0",
               n, best_sad, best_row, best_lane);
    end
    handshake();
  endtask

  task automatic test_bubbles();
    int n;
    send_window(0, 0, R-1, 1'b1);
    wait_out(n);
    nvec++;
    if (n !== 3) begin
      nfail++;
      $display("FAIL bub_latency: got %0d cycles, required 3", n);
    end
    for (int c = 0; c < 10; c++) begin
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || best_sad !== 11'd3 ||
          best_row !== 4'd5 || best_lane !== 4'd9) begin
        nfail++;
        $display("FAIL bub_hold c%0d: got ov=%b rdy=%b %0d/%0d/%0d, required ov=1 rdy=0 3/5/9",
                 c, out_valid, in_ready, best_sad, best_row, best_lane);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL bub_release: got ov=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_window(2, 0, 6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if (out_valid !== 1'b0 || best_sad !== 11'd0) begin
      nfail++;
      $display("FAIL midrst_clear: got ov=%b sad=%0d, required ov=0 sad=0",
               out_valid, best_sad);
    end
    send_window(3, 0, R-1, 1'b0);
    wait_out(n);
    nvec++;
    if (n !== 3 || best_sad !== 11'd20 || best_row !== 4'd15 || best_lane !== 4'd0) begin
      nfail++;
      $display("FAIL midrst_result: got lat=%0d %0d/%0d/%0d, required lat=3 20/15/0",
               n, best_sad, best_row, best_lane);
    end
    handshake();
  endtask

  task automatic test_extremes();
    int n;
    send_window(4, 0, R-1, 1'b0);
    wait_out(n);
    nvec++;
    if (best_sad !== 11'd0 || best_row !== 4'd7 || best_lane !== 4'd12) begin
      nfail++;
      $display("FAIL ext_zero: got %0d/%0d/%0d, required 0/7/12",
               best_sad, best_row, best_lane);
    end
`ifdef PSAD_MIN_SAT_FLAG_EN
    nvec++;
    if (sat_seen !== 1'b1) begin
      nfail++;
      $display("FAIL ext_sat_set: got %b, required 1", sat_seen);
    end
`endif
    handshake();
`ifdef PSAD_MIN_SAT_FLAG_EN
    nvec++;
    if (sat_seen !== 1'b0) begin
      nfail++;
      $display("FAIL ext_sat_clear: got %b, required 0", sat_seen);
    end
`endif
    send_window(5, 0, R-1, 1'b0);
    wait_out(n);
    nvec++;
    if (best_sad !== 11'd1000 || best_row !== 4'd0 || best_lane !== 4'd3) begin
      nfail++;
      $display("FAIL ext_2046: got %0d/%0d/%0d, required 1000/0/3",
               best_sad, best_row, best_lane);
    end
`ifdef PSAD_MIN_SAT_FLAG_EN
    nvec++;
    if (sat_seen !== 1'b0) begin
      nfail++;
      $display("FAIL ext_sat_2046: got %b, required 0", sat_seen);
    end
`endif
    handshake();
  endtask

  task automatic test_back_to_back();
    int r, k, n;
    int acc[2*R];
    int hs[2];
    logic [18:0] res[2];
    r = 0;
    k = 0;
    n = 0;
    for (int j = 0; j < 2*R; j++) acc[j] = 0;
    hs[0] = 0;
    hs[1] = 0;
    res[0] = '0;
    res[1] = '0;
    out_ready = 1'b1;
    while (k < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        res[k] = {best_sad, best_row, best_lane};
        hs[k] = cyc + 1;
        k++;
      end
      if (r < 2*R) begin
        drive_row((r < R) ? 6 : 7, r % R);
        in_valid = 1'b1;
        if (in_ready) begin
          acc[r] = cyc + 1;
          r++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    nvec++;
    if (k !== 2) begin
      nfail++;
      $display("FAIL b2b_timeout: got %0d results, required 2", k);
    end
    nvec++;
    if (res[0] !== {11'd7, 4'd10, 4'd2}) begin
      nfail++;
      $display("FAIL b2b_first: got %0d/%0d/%0d, required 7/10/2",
               res[0][18:8], res[0][7:4], res[0][3:0]);
    end
    nvec++;
    if (res[1] !== {11'd9, 4'd0, 4'd15}) begin
      nfail++;
      $display("FAIL b2b_second: got %0d/%0d/%0d, required 9/0/15",
               res[1][18:8], res[1][7:4], res[1][3:0]);
    end
    nvec++;
    if (hs[0] - acc[R-1] !== 3) begin
      nfail++;
      $display("FAIL b2b_hs_gap: got %0d, required 3", hs[0] - acc[R-1]);
    end
    nvec++;
    if (acc[R] - hs[0] !== 1) begin
      nfail++;
      $display("FAIL b2b_restart: got %0d, required 1", acc[R] - hs[0]);
    end
    nvec++;
    if (acc[R] - acc[0] !== R + 3) begin
      nfail++;
      $display("FAIL b2b_period: got %0d, required %0d", acc[R] - acc[0], R + 3);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_ties();
    test_bubbles();
    test_reset_mid();
    test_extremes();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
